// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, access size codes and width defaults for mem_ctrl
package mem_ctrl_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int WORD_W_DEF = 32;
  typedef enum logic [2:0] {IDLE, IF_HIT, IF_READ, MEM_READ, MEM_WRITE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    return sz == SZ_WORD ? 3'd4 : sz == SZ_HALF ? 3'd2 : sz == SZ_BYTE ? 3'd1 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl_cache.sv
// cache: 256-entry direct-mapped word cache, 5-bit tag, combinational lookup
module cache
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              work,
  input  logic [WORD_W-1:0] wdata,
  output logic              hit,
  output logic [WORD_W-1:0] rdata
);
  logic [255:0] valid;
  logic [4:0] tags [256];
  logic [WORD_W-1:0] data [256];
  logic [7:0] idx;
  logic [4:0] tag;
  logic unused_addr;
  assign idx = addr[9:2];
  assign tag = addr[14:10];
  assign unused_addr = ^{addr[ADDR_W-1:15], addr[1:0]};
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else if (work) valid[idx] <= 1'b1;
  always_ff @(posedge clk)
    if (work) begin
      tags[idx] <= tag;
      data[idx] <= wdata;
    end
  assign hit = valid[idx] && tags[idx] == tag;
  assign rdata = data[idx];
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM port between instruction fetch (via icache) and data loads/stores
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_done,
  output logic [WORD_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [WORD_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);
  state_t state, state_n;
  logic [2:0] s, n;
  logic [ADDR_W-1:0] base, ca;
  logic [WORD_W-1:0] wd, buffer, crd;
  logic hit, work, rd_st, fin;
  assign rd_st = state == IF_READ || state == MEM_READ;
  // reads need one extra stage because ram_din lags its address by a cycle
  assign fin = rd_st ? s == n + 3'd1 : s == n;
  assign ca = state == IDLE ? if_addr : base;
  assign work = state == IF_READ && rdy && !flush && s == n;
  cache #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) icache (
    .clk(clk),
    .rst(rst),
    .addr(ca),
    .work(work),
    .wdata({ram_din, buffer[WORD_W-9:0]}),
    .hit(hit),
    .rdata(crd)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = mem_req ? (mem_we ? MEM_WRITE : MEM_READ) : (if_req && !flush) ? (hit ? IF_HIT : IF_READ) : IDLE;
    else if (state == IF_HIT || fin || (state == IF_READ && flush))
      state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      base <= '0;
      wd <= '0;
      buffer <= '0;
    end else if (rdy) begin
      state <= state_n;
      if (state == IDLE) begin
        s <= '0;
        base <= mem_req ? mem_addr : if_addr;
        wd <= mem_wdata;
        n <= mem_req ? nbytes(mem_size) : 3'd4;
        if (!mem_req && if_req && !flush && hit) buffer <= crd;
      end else begin
        s <= s + 3'd1;
        if (rd_st && s == 3'd0) buffer <= '0;
        if (rd_st && s != 3'd0 && s <= n) buffer[{s[1:0] - 2'd1, 3'b000} +: 8] <= ram_din;
      end
    end else s <= '0;
  assign if_done = !rst && rdy && !flush && (state == IF_HIT || (state == IF_READ && fin));
  assign mem_done = !rst && rdy && (state == MEM_READ || state == MEM_WRITE) && fin;
  assign if_inst = buffer;
  assign mem_rdata = buffer;
  always_comb begin
    ram_addr = '0;
    ram_wr = 1'b0;
    ram_dout = 8'h00;
    if (!rst && (rd_st || state == MEM_WRITE) && s < n) begin
      ram_addr = base + ADDR_W'(s);
      ram_wr = state == MEM_WRITE && rdy;
      ram_dout = state == MEM_WRITE ? wd[{s[1:0], 3'b000} +: 8] : 8'h00;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: random and directed transactions checked against a byte-array memory and a line-level cache model
module tb_mem_ctrl;
  logic clk = 0, rst = 1, rdy = 1, if_req = 0, flush = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [1:0] mem_size = 0;
  logic if_done, mem_done, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_addr;
  logic [7:0] ram_dout, ram_din = 0;
  int errors = 0, checks = 0;
  logic [7:0] ram [65536];
  logic [7:0] rm [65536];
  bit cv [256];
  logic [31:0] ctag [256], cd [256];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .flush(flush), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // external RAM: byte read data valid one cycle after the address
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[15:0]];
    if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ix(input logic [31:0] x);
    return x[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = 0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = rm[ix(a + 32'(i))];
    return w;
  endfunction

  // kind: 0 fetch, 1 load, 2 store; pause = cycle index with rdy low (0 = none)
  task automatic op(input int kind, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input int pause);
    int n, lat, seen, wrong, e;
    logic hit;
    logic [31:0] exp_d, got, ea;
    logic [7:0] idx;
    idx = a[9:2];
    hit = kind == 0 && cv[idx] && ctag[idx] == a;
    n = kind == 0 ? 4 : sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    lat = hit ? 1 : kind == 2 ? n + 1 : n + 2;
    exp_d = hit ? cd[idx] : kind == 2 ? 32'h0 : ref_word(a, n);
    seen = 0; wrong = 0; got = 0;
    @(posedge clk); #1;
    if (kind == 0) begin if_req = 1; if_addr = a; end
    else begin mem_req = 1; mem_we = kind == 2; mem_size = sz; mem_addr = a; mem_wdata = wd; end
    @(posedge clk);
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      #1;
      if (c == pause) rdy = 0;
      if (c == pause + 1) rdy = 1;
      @(negedge clk);
      e = (pause > 0 && c > pause) ? c - pause : c;
      ea = a + 32'(e) - 32'd1;
      if (c == pause) check("pause_wr", {63'h0, ram_wr}, 0);
      else if (hit) check("hit_quiet", {31'h0, ram_wr, ram_addr}, 0);
      else if (e <= n) begin
        check("ram_addr", {32'h0, ram_addr}, {32'h0, ea});
        check("ram_wr", {63'h0, ram_wr}, kind == 2);
        if (kind == 2) check("ram_dout", {56'h0, ram_dout}, {56'h0, wd[8*(e-1) +: 8]});
      end
      if (kind == 0 ? mem_done : if_done) wrong++;
      if (kind == 0 ? if_done : mem_done) begin
        seen = c;
        got = kind == 0 ? if_inst : mem_rdata;
      end
      @(posedge clk);
    end
    #1;
    if_req = 0; mem_req = 0; rdy = 1;
    check(kind == 0 ? "if_latency" : "mem_latency", 64'(seen), 64'(lat + pause * int'(pause > 0 && pause <= lat)));
    check("stray_done", 64'(wrong), 0);
    if (kind != 2) check(kind == 0 ? "if_inst" : "mem_rdata", {32'h0, got}, {32'h0, exp_d});
    if (kind == 0 && !hit && seen != 0) begin cv[idx] = 1; ctag[idx] = a; cd[idx] = exp_d; end
    if (kind == 2) for (int i = 0; i < n; i++) rm[ix(a + 32'(i))] = wd[8*i +: 8];
  endtask

  task automatic reset_outputs(input string tag);
    check(tag, {if_done, mem_done, ram_wr, ram_dout, ram_addr}, 0);
    check(tag, {if_inst, mem_rdata}, 0);
  endtask

  initial begin
    int md, idn, cnt, k;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
      rm[i] = ram[i];
    end
    {ram[16'h100], ram[16'h101], ram[16'h102], ram[16'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
    {rm[16'h100], rm[16'h101], rm[16'h102], rm[16'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) cv[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outputs("reset_out");
    @(posedge clk); #1 rst = 0;

    op(0, 32'h100, 0, 0, 0);
    check("first_inst", {32'h0, if_inst}, 64'h513);
    op(0, 32'h100, 0, 0, 0);

    // MEM wins over a simultaneous IF; IF miss follows once MEM completes
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h200; mem_req = 1; mem_we = 0; mem_size = 2'd2; mem_addr = 32'h1000;
    @(posedge clk);
    md = 0; idn = 0;
    for (int c = 1; c <= 30 && idn == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("arb_mem_first", {32'h0, ram_addr}, 64'h1000);
      if (c == 8) check("arb_if_addr", {32'h0, ram_addr}, 64'h200);
      if (mem_done && md == 0) begin md = c; check("arb_rdata", {32'h0, mem_rdata}, {32'h0, ref_word(32'h1000, 4)}); end
      if (if_done && idn == 0) begin idn = c; check("arb_inst", {32'h0, if_inst}, {32'h0, ref_word(32'h200, 4)}); end
      @(posedge clk); #1;
      if (md == c) mem_req = 0;
      if (idn == c) if_req = 0;
    end
    mem_req = 0; if_req = 0;
    check("arb_mem_lat", 64'(md), 6);
    check("arb_if_lat", 64'(idn), 13);
    cv[8'h80] = 1; ctag[8'h80] = 32'h200; cd[8'h80] = ref_word(32'h200, 4);

    op(2, 32'h1002, 2'd1, 32'hBEEF, 0);
    op(1, 32'h1000, 2'd2, 0, 0);

    // flush in c3 of a miss: no if_done and no fill
    @(posedge clk); #1 if_req = 1; if_addr = 32'h300;
    repeat (3) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0; if_req = 0;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (if_done) cnt++; end
    check("flush_nodone", 64'(cnt), 0);
    op(0, 32'h300, 0, 0, 0);
    check("flush_refetch", {32'h0, if_inst}, {32'h0, ref_word(32'h300, 4)});

    op(1, 32'h100, 2'd2, 0, 3);
    op(2, 32'h120, 2'd2, 32'hCAFEF00D, 3);
    op(1, 32'h120, 2'd3, 0, 0);
    op(2, 32'hFFFF_FFFE, 2'd2, 32'h89ABCDEF, 0);
    op(1, 32'hFFFF_FFFE, 2'd2, 0, 0);
    op(1, 32'h0000_0001, 2'd0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 2);
      a = k == 0 ? 32'h100 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) != 0 ? 32'h400 : 32'h0)
                 : 32'h100 + 32'($urandom_range(0, 127));
      op(k, a, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 7) == 0 ? $urandom_range(2, 3) : 0);
    end

    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    reset_outputs("midrun_reset");
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 256; i++) cv[i] = 0;
    op(0, 32'h100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
